// File: rtl/exc_pkg.sv
// Shared definitions for the ARM exception entry sequencer.
// Holds the processor mode encodings, register-bank override codes,
// exception codes, vector offsets, the entry FSM state type, CPSR bit
// positions, and small lookup helpers. The helpers map an exception
// code to its target mode, bank code, vector offset and entry CPSR.
package exc_pkg;

   // Processor mode field values (CPSR[4:0])
   localparam logic [4:0] MODE_USR = 5'b10000;
   localparam logic [4:0] MODE_FIQ = 5'b10001;
   localparam logic [4:0] MODE_IRQ = 5'b10010;
   localparam logic [4:0] MODE_SVC = 5'b10011;
   localparam logic [4:0] MODE_UND = 5'b11011;
   localparam logic [4:0] MODE_SYS = 5'b11111;

   // Register-bank override codes driven on change_m
   localparam logic [2:0] CM_NONE = 3'd0;
   localparam logic [2:0] CM_FIQ  = 3'd1;
   localparam logic [2:0] CM_IRQ  = 3'd2;
   localparam logic [2:0] CM_SVC  = 3'd3;
   localparam logic [2:0] CM_UND  = 3'd4;

   // Exception codes driven on exc_taken
   localparam logic [2:0] EXC_NONE = 3'd0;
   localparam logic [2:0] EXC_FIQ  = 3'd1;
   localparam logic [2:0] EXC_IRQ  = 3'd2;
   localparam logic [2:0] EXC_SWI  = 3'd3;
   localparam logic [2:0] EXC_UND  = 3'd4;

   // Vector offsets from the vector base
   localparam logic [7:0] VEC_UND = 8'h04;
   localparam logic [7:0] VEC_SWI = 8'h08;
   localparam logic [7:0] VEC_IRQ = 8'h18;
   localparam logic [7:0] VEC_FIQ = 8'h1C;

   // CPSR control bit positions
   localparam int I_BIT = 7;
   localparam int F_BIT = 6;
   localparam int T_BIT = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SAVE_LR,
      ST_SAVE_PSR,
      ST_LOAD_PC
   } exc_state_t;

   function automatic logic [4:0] mode_of(input logic [2:0] code);
      case (code)
         EXC_FIQ: mode_of = MODE_FIQ;
         EXC_IRQ: mode_of = MODE_IRQ;
         EXC_SWI: mode_of = MODE_SVC;
         EXC_UND: mode_of = MODE_UND;
         default: mode_of = MODE_USR;
      endcase
   endfunction

   function automatic logic [2:0] cm_of(input logic [2:0] code);
      case (code)
         EXC_FIQ: cm_of = CM_FIQ;
         EXC_IRQ: cm_of = CM_IRQ;
         EXC_SWI: cm_of = CM_SVC;
         EXC_UND: cm_of = CM_UND;
         default: cm_of = CM_NONE;
      endcase
   endfunction

   function automatic logic [7:0] vec_of(input logic [2:0] code);
      case (code)
         EXC_FIQ: vec_of = VEC_FIQ;
         EXC_IRQ: vec_of = VEC_IRQ;
         EXC_SWI: vec_of = VEC_SWI;
         EXC_UND: vec_of = VEC_UND;
         default: vec_of = 8'h00;
      endcase
   endfunction

   // Entry CPSR: new mode, IRQs disabled, ARM state, and FIQs disabled
   // only when entering FIQ mode.
   function automatic logic [31:0] entry_psr(input logic [31:0] psr,
                                             input logic [2:0]  code);
      logic [31:0] r;
      r        = psr;
      r[4:0]   = mode_of(code);
      r[I_BIT] = 1'b1;
      r[T_BIT] = 1'b0;
      if (code == EXC_FIQ) begin
         r[F_BIT] = 1'b1;
      end
      entry_psr = r;
   endfunction

endpackage

// File: rtl/exc_priority_enc.sv
// Combinational priority encoder for pending exceptions.
// Ports:
//   fiq, irq         level interrupt requests
//   f_mask, i_mask   CPSR F and I bits (1 = masked)
//   und_pend         latched undefined-instruction request
//   swi_pend         latched SWI request
//   valid            some candidate is present
//   code             exception code of the winner (FIQ > IRQ > UND > SWI)
module exc_priority_enc
   import exc_pkg::*;
(
   input  logic       fiq,
   input  logic       irq,
   input  logic       f_mask,
   input  logic       i_mask,
   input  logic       und_pend,
   input  logic       swi_pend,
   output logic       valid,
   output logic [2:0] code
);

   // Fixed priority chain; masked interrupts simply drop out of the race.
   always_comb begin
      valid = 1'b1;
      code  = EXC_NONE;
      if (fiq && !f_mask) begin
         code = EXC_FIQ;
      end else if (irq && !i_mask) begin
         code = EXC_IRQ;
      end else if (und_pend) begin
         code = EXC_UND;
      end else if (swi_pend) begin
         code = EXC_SWI;
      end else begin
         valid = 1'b0;
      end
   end

endmodule

// File: rtl/exception_sequencer.sv
// ARM exception entry sequencer.
// At an instruction boundary picks the highest-priority unmasked pending
// exception, then over three cycles writes the banked LR, saves SPSR and
// updates CPSR, and finally loads the vector PC. busy stalls the core.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   fiq, irq                 level interrupt requests
//   und_req, swi_req         one-cycle decoder pulses (latched until taken)
//   instr_done               instruction boundary
//   cpsr, pc_cur             current CPSR and next sequential PC
//   busy                     entry sequence in progress
//   change_m                 register-bank override code
//   write_reg/w_addr/w_data  register-file write port
//   write_pc/pc_new          PC load
//   cpsr_we/cpsr_new         CPSR write
//   spsr_we/spsr_mode/spsr_data  SPSR write
//   exc_taken                one-cycle code of the exception taken
module exception_sequencer
   import exc_pkg::*;
#(
   parameter logic [31:0] VECTOR_BASE = 32'h0000_0000
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        fiq,
   input  logic        irq,
   input  logic        und_req,
   input  logic        swi_req,
   input  logic        instr_done,
   input  logic [31:0] cpsr,
   input  logic [31:0] pc_cur,
   output logic        busy,
   output logic [2:0]  change_m,
   output logic        write_reg,
   output logic [3:0]  w_addr,
   output logic [31:0] w_data,
   output logic        write_pc,
   output logic [31:0] pc_new,
   output logic        cpsr_we,
   output logic [31:0] cpsr_new,
   output logic        spsr_we,
   output logic [4:0]  spsr_mode,
   output logic [31:0] spsr_data,
   output logic [2:0]  exc_taken
);

   exc_state_t  state, state_next;
   logic        und_pend, swi_pend;
   logic [31:0] saved_psr;
   logic [2:0]  sel_code;
   logic        enc_valid;
   logic [2:0]  enc_code;
   logic        take;

   logic        busy_nx, write_reg_nx, write_pc_nx, cpsr_we_nx, spsr_we_nx;
   logic [2:0]  change_m_nx, exc_taken_nx;
   logic [3:0]  w_addr_nx;
   logic [31:0] w_data_nx, pc_new_nx, cpsr_new_nx, spsr_data_nx;
   logic [4:0]  spsr_mode_nx;

   exc_priority_enc u_prio (
      .fiq      (fiq),
      .irq      (irq),
      .f_mask   (cpsr[F_BIT]),
      .i_mask   (cpsr[I_BIT]),
      .und_pend (und_pend),
      .swi_pend (swi_pend),
      .valid    (enc_valid),
      .code     (enc_code)
   );

   assign take = (state == ST_IDLE) && instr_done && enc_valid;

   // Outputs are registered, so this block computes the outputs belonging
   // to the state being entered: leaving IDLE produces the SAVE_LR strobes,
   // leaving SAVE_LR produces SAVE_PSR strobes, and so on. The LR write
   // uses live inputs because it is emitted on the selection edge itself.
   always_comb begin
      state_next   = state;
      busy_nx      = 1'b0;
      change_m_nx  = CM_NONE;
      write_reg_nx = 1'b0;
      w_addr_nx    = 4'd0;
      w_data_nx    = 32'd0;
      write_pc_nx  = 1'b0;
      pc_new_nx    = 32'd0;
      cpsr_we_nx   = 1'b0;
      cpsr_new_nx  = 32'd0;
      spsr_we_nx   = 1'b0;
      spsr_mode_nx = 5'd0;
      spsr_data_nx = 32'd0;
      exc_taken_nx = EXC_NONE;
      case (state)
         ST_IDLE: begin
            if (take) begin
               state_next   = ST_SAVE_LR;
               busy_nx      = 1'b1;
               exc_taken_nx = enc_code;
               change_m_nx  = cm_of(enc_code);
               write_reg_nx = 1'b1;
               w_addr_nx    = 4'd14;
               w_data_nx    = ((enc_code == EXC_FIQ) || (enc_code == EXC_IRQ))
                              ? pc_cur + 32'd4 : pc_cur;
            end
         end
         ST_SAVE_LR: begin
            state_next   = ST_SAVE_PSR;
            busy_nx      = 1'b1;
            change_m_nx  = cm_of(sel_code);
            spsr_we_nx   = 1'b1;
            spsr_mode_nx = mode_of(sel_code);
            spsr_data_nx = saved_psr;
            cpsr_we_nx   = 1'b1;
            cpsr_new_nx  = entry_psr(saved_psr, sel_code);
         end
         ST_SAVE_PSR: begin
            state_next   = ST_LOAD_PC;
            busy_nx      = 1'b1;
            write_pc_nx  = 1'b1;
            pc_new_nx    = VECTOR_BASE + {24'd0, vec_of(sel_code)};
         end
         ST_LOAD_PC: begin
            state_next   = ST_IDLE;
         end
         default: begin
            state_next   = ST_IDLE;
         end
      endcase
   end

   // State, capture registers, pending latches and registered outputs.
   // A request pulse always sets its latch, even on the edge that clears
   // it for the exception being taken, so no pulse is ever lost.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         und_pend  <= 1'b0;
         swi_pend  <= 1'b0;
         saved_psr <= 32'd0;
         sel_code  <= EXC_NONE;
         busy      <= 1'b0;
         change_m  <= CM_NONE;
         write_reg <= 1'b0;
         w_addr    <= 4'd0;
         w_data    <= 32'd0;
         write_pc  <= 1'b0;
         pc_new    <= 32'd0;
         cpsr_we   <= 1'b0;
         cpsr_new  <= 32'd0;
         spsr_we   <= 1'b0;
         spsr_mode <= 5'd0;
         spsr_data <= 32'd0;
         exc_taken <= EXC_NONE;
      end else begin
         state     <= state_next;
         und_pend  <= (und_pend && !(take && (enc_code == EXC_UND))) || und_req;
         swi_pend  <= (swi_pend && !(take && (enc_code == EXC_SWI))) || swi_req;
         if (take) begin
            saved_psr <= cpsr;
            sel_code  <= enc_code;
         end
         busy      <= busy_nx;
         change_m  <= change_m_nx;
         write_reg <= write_reg_nx;
         w_addr    <= w_addr_nx;
         w_data    <= w_data_nx;
         write_pc  <= write_pc_nx;
         pc_new    <= pc_new_nx;
         cpsr_we   <= cpsr_we_nx;
         cpsr_new  <= cpsr_new_nx;
         spsr_we   <= spsr_we_nx;
         spsr_mode <= spsr_mode_nx;
         spsr_data <= spsr_data_nx;
         exc_taken <= exc_taken_nx;
      end
   end

endmodule

// File: tb/tb_exception_sequencer.sv
// Self-checking bench for exception_sequencer: a table of per-cycle
// input/expected-output records plus hand-written multi-cycle sequences.
// A second instance with high vectors checks the VECTOR_BASE path.
module tb_exception_sequencer;

   localparam logic [31:0] HI_BASE = 32'hFFFF_0000;

   typedef struct {
      logic        rst;
      logic        fiq;
      logic        irq;
      logic        und;
      logic        swi;
      logic        done;
      logic [31:0] cpsr;
      logic [31:0] pc;
   } stim_t;

   typedef struct {
      logic        busy;
      logic [2:0]  change_m;
      logic        write_reg;
      logic [3:0]  w_addr;
      logic [31:0] w_data;
      logic        write_pc;
      logic [31:0] pc_new;
      logic        cpsr_we;
      logic [31:0] cpsr_new;
      logic        spsr_we;
      logic [4:0]  spsr_mode;
      logic [31:0] spsr_data;
      logic [2:0]  exc_taken;
   } resp_t;

   typedef struct {
      stim_t s;
      resp_t r;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, fiq, irq, und_req, swi_req, instr_done;
   logic [31:0] cpsr, pc_cur;
   logic        busy, write_reg, write_pc, cpsr_we, spsr_we;
   logic [2:0]  change_m, exc_taken;
   logic [3:0]  w_addr;
   logic [31:0] w_data, pc_new, cpsr_new, spsr_data;
   logic [4:0]  spsr_mode;

   logic        h_busy, h_write_reg, h_write_pc, h_cpsr_we, h_spsr_we;
   logic [2:0]  h_change_m, h_exc_taken;
   logic [3:0]  h_w_addr;
   logic [31:0] h_w_data, h_pc_new, h_cpsr_new, h_spsr_data;
   logic [4:0]  h_spsr_mode;

   int checkCount = 0;
   int passCount  = 0;
   vec_t vecs[$];

   always #5 clk = ~clk;

   exception_sequencer dut (
      .clk(clk), .rst(rst), .fiq(fiq), .irq(irq), .und_req(und_req),
      .swi_req(swi_req), .instr_done(instr_done), .cpsr(cpsr), .pc_cur(pc_cur),
      .busy(busy), .change_m(change_m), .write_reg(write_reg), .w_addr(w_addr),
      .w_data(w_data), .write_pc(write_pc), .pc_new(pc_new), .cpsr_we(cpsr_we),
      .cpsr_new(cpsr_new), .spsr_we(spsr_we), .spsr_mode(spsr_mode),
      .spsr_data(spsr_data), .exc_taken(exc_taken)
   );

   exception_sequencer #(.VECTOR_BASE(HI_BASE)) dutHi (
      .clk(clk), .rst(rst), .fiq(fiq), .irq(irq), .und_req(und_req),
      .swi_req(swi_req), .instr_done(instr_done), .cpsr(cpsr), .pc_cur(pc_cur),
      .busy(h_busy), .change_m(h_change_m), .write_reg(h_write_reg),
      .w_addr(h_w_addr), .w_data(h_w_data), .write_pc(h_write_pc),
      .pc_new(h_pc_new), .cpsr_we(h_cpsr_we), .cpsr_new(h_cpsr_new),
      .spsr_we(h_spsr_we), .spsr_mode(h_spsr_mode), .spsr_data(h_spsr_data),
      .exc_taken(h_exc_taken)
   );

   function automatic stim_t st(input logic r, input logic f, input logic i,
                                input logic u, input logic s, input logic d,
                                input logic [31:0] c, input logic [31:0] p);
      stim_t x;
      x.rst = r; x.fiq = f; x.irq = i; x.und = u; x.swi = s; x.done = d;
      x.cpsr = c; x.pc = p;
      return x;
   endfunction

   function automatic resp_t expIdle();
      resp_t x;
      x = '{default: '0};
      return x;
   endfunction

   function automatic resp_t expLr(input logic [2:0] code, input logic [2:0] cm,
                                   input logic [31:0] lr);
      resp_t x;
      x = '{default: '0};
      x.busy = 1'b1; x.exc_taken = code; x.change_m = cm;
      x.write_reg = 1'b1; x.w_addr = 4'd14; x.w_data = lr;
      return x;
   endfunction

   function automatic resp_t expPsr(input logic [2:0] cm, input logic [4:0] mode,
                                    input logic [31:0] spsr, input logic [31:0] cpsrNew);
      resp_t x;
      x = '{default: '0};
      x.busy = 1'b1; x.change_m = cm;
      x.spsr_we = 1'b1; x.spsr_mode = mode; x.spsr_data = spsr;
      x.cpsr_we = 1'b1; x.cpsr_new = cpsrNew;
      return x;
   endfunction

   function automatic resp_t expPc(input logic [31:0] pc);
      resp_t x;
      x = '{default: '0};
      x.busy = 1'b1; x.write_pc = 1'b1; x.pc_new = pc;
      return x;
   endfunction

   function automatic vec_t vv(input stim_t s, input resp_t r);
      vec_t x;
      x.s = s; x.r = r;
      return x;
   endfunction

   task automatic applyStimulus(input stim_t s);
      rst = s.rst; fiq = s.fiq; irq = s.irq; und_req = s.und; swi_req = s.swi;
      instr_done = s.done; cpsr = s.cpsr; pc_cur = s.pc;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      checkCount++;
      if (act === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic checkVector(input int i, input logic strict, input resp_t r);
      string p;
      p = $sformatf("v%0d.", i);
      checkOutput({p, "busy"},      32'(busy),      32'(r.busy));
      checkOutput({p, "change_m"},  32'(change_m),  32'(r.change_m));
      checkOutput({p, "write_reg"}, 32'(write_reg), 32'(r.write_reg));
      checkOutput({p, "w_addr"},    32'(w_addr),    32'(r.w_addr));
      checkOutput({p, "w_data"},    w_data,         r.w_data);
      checkOutput({p, "write_pc"},  32'(write_pc),  32'(r.write_pc));
      checkOutput({p, "pc_new"},    pc_new,         r.pc_new);
      checkOutput({p, "cpsr_we"},   32'(cpsr_we),   32'(r.cpsr_we));
      checkOutput({p, "spsr_we"},   32'(spsr_we),   32'(r.spsr_we));
      checkOutput({p, "exc_taken"}, 32'(exc_taken), 32'(r.exc_taken));
      checkOutput({p, "hi_pc_new"}, h_pc_new, r.write_pc ? HI_BASE + r.pc_new : 32'd0);
      if (strict || r.cpsr_we) begin
         checkOutput({p, "cpsr_new"}, cpsr_new, r.cpsr_new);
      end
      if (strict || r.spsr_we) begin
         checkOutput({p, "spsr_mode"}, 32'(spsr_mode), 32'(r.spsr_mode));
         checkOutput({p, "spsr_data"}, spsr_data, r.spsr_data);
      end
   endtask

   initial begin
      int waited;
      int strays;
      applyStimulus(st(1, 0, 0, 0, 0, 0, 32'h10, 32'h0));

      // Reset, then IRQ entry from user mode with pc_cur=0x100
      vecs.push_back(vv(st(1,0,0,0,0,0,32'h10,32'h0),   expIdle()));
      vecs.push_back(vv(st(0,0,0,0,0,1,32'h10,32'h0),   expIdle()));
      vecs.push_back(vv(st(0,0,1,0,0,1,32'h10,32'h100), expLr(3'd2, 3'd2, 32'h104)));
      vecs.push_back(vv(st(0,0,1,0,0,0,32'h10,32'h100), expPsr(3'd2, 5'b10010, 32'h10, 32'h92)));
      vecs.push_back(vv(st(0,0,1,0,0,0,32'h10,32'h100), expPc(32'h18)));
      vecs.push_back(vv(st(0,0,0,0,0,0,32'h10,32'h100), expIdle()));
      // FIQ beats IRQ; afterwards IRQ is masked by the new CPSR
      vecs.push_back(vv(st(0,1,1,0,0,1,32'h10,32'h300), expLr(3'd1, 3'd1, 32'h304)));
      vecs.push_back(vv(st(0,1,1,0,0,1,32'h10,32'h300), expPsr(3'd1, 5'b10001, 32'h10, 32'hD1)));
      vecs.push_back(vv(st(0,0,1,0,0,1,32'hD1,32'h300), expPc(32'h1C)));
      vecs.push_back(vv(st(0,0,1,0,0,1,32'hD1,32'h300), expIdle()));
      vecs.push_back(vv(st(0,0,1,0,0,1,32'hD1,32'h300), expIdle()));
      // SWI with IRQ masked; SWI pulse is latched first
      vecs.push_back(vv(st(0,0,0,0,1,0,32'h90,32'h200), expIdle()));
      vecs.push_back(vv(st(0,0,1,0,0,1,32'h90,32'h200), expLr(3'd3, 3'd3, 32'h200)));
      vecs.push_back(vv(st(0,0,1,0,0,0,32'h90,32'h200), expPsr(3'd3, 5'b10011, 32'h90, 32'h93)));
      vecs.push_back(vv(st(0,0,1,0,0,0,32'h90,32'h200), expPc(32'h08)));
      vecs.push_back(vv(st(0,0,0,0,0,0,32'h90,32'h200), expIdle()));
      // IRQ with LR wrap-around; UND pulse while busy taken afterwards
      vecs.push_back(vv(st(0,0,1,0,0,1,32'h10,32'hFFFF_FFFC), expLr(3'd2, 3'd2, 32'h0)));
      vecs.push_back(vv(st(0,0,1,1,0,1,32'h10,32'hFFFF_FFFC), expPsr(3'd2, 5'b10010, 32'h10, 32'h92)));
      vecs.push_back(vv(st(0,0,0,0,0,1,32'h92,32'h500), expPc(32'h18)));
      vecs.push_back(vv(st(0,0,0,0,0,1,32'h92,32'h500), expIdle()));
      vecs.push_back(vv(st(0,0,0,0,0,1,32'h92,32'h500), expLr(3'd4, 3'd4, 32'h500)));
      vecs.push_back(vv(st(0,0,0,0,0,0,32'h92,32'h500), expPsr(3'd4, 5'b11011, 32'h92, 32'h9B)));
      vecs.push_back(vv(st(0,0,0,0,0,0,32'h92,32'h500), expPc(32'h04)));
      vecs.push_back(vv(st(0,0,0,0,0,0,32'h92,32'h500), expIdle()));

      $display("[TB] applying %0d table vectors", vecs.size());
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].s);
         step();
         checkVector(i, vecs[i].s.rst, vecs[i].r);
      end

      // Reset during SAVE_PSR: sequence aborts and the UND latch is cleared
      applyStimulus(st(0,0,1,0,0,1,32'h10,32'h600));
      step();
      checkOutput("rstSeq.exc_taken", 32'(exc_taken), 32'd2);
      applyStimulus(st(0,0,1,1,0,0,32'h10,32'h600));
      step();
      checkOutput("rstSeq.in_save_psr", 32'(spsr_we), 32'd1);
      applyStimulus(st(1,0,1,0,0,0,32'h10,32'h600));
      step();
      checkOutput("rstSeq.busy",      32'(busy),      32'd0);
      checkOutput("rstSeq.write_pc",  32'(write_pc),  32'd0);
      checkOutput("rstSeq.pc_new",    pc_new,         32'd0);
      checkOutput("rstSeq.cpsr_we",   32'(cpsr_we),   32'd0);
      checkOutput("rstSeq.spsr_we",   32'(spsr_we),   32'd0);
      checkOutput("rstSeq.cpsr_new",  cpsr_new,       32'd0);
      checkOutput("rstSeq.change_m",  32'(change_m),  32'd0);
      applyStimulus(st(0,0,0,0,0,1,32'h10,32'h700));
      strays = 0;
      for (int c = 0; c < 6; c++) begin
         step();
         if (exc_taken != 3'd0 || write_pc || write_reg) strays++;
      end
      checkOutput("rstSeq.latch_cleared", 32'(strays), 32'd0);

      // UND pulse on the same edge as an IRQ selection: taken later
      applyStimulus(st(0,0,1,1,0,1,32'h10,32'h800));
      step();
      checkOutput("simul.first_taken", 32'(exc_taken), 32'd2);
      applyStimulus(st(0,0,0,0,0,1,32'h92,32'h900));
      waited = 0;
      do begin
         step();
         waited++;
      end while (exc_taken == 3'd0 && waited < 10);
      checkOutput("simul.second_taken", 32'(exc_taken), 32'd4);
      checkOutput("simul.latency",      32'(waited),    32'd4);
      checkOutput("simul.lr",           w_data,         32'h900);
      applyStimulus(st(0,0,0,0,0,0,32'h92,32'h900));
      for (int c = 0; c < 4; c++) step();
      checkOutput("simul.idle_busy", 32'(busy), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/exception_sequencer.md
# exception_sequencer

Sequences ARM exception entry (FIQ, IRQ, undefined instruction, SWI) onto the banked register file and PSR registers. At each instruction boundary it picks the highest-priority unmasked pending exception, then over three cycles writes the banked LR, saves the SPSR, updates the CPSR and loads the vector PC. It sits between the CPU control unit / interrupt pins and the register file, and stalls the control unit (`busy`) while it owns the write ports.

## Interface
Parameters:
- `VECTOR_BASE`, default 32'h0000_0000: base added to the vector offset (32'hFFFF_0000 for high vectors).

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `fiq`  in  1  level FIQ request, held by source until serviced.
- `irq`  in  1  level IRQ request, held by source until serviced.
- `und_req`  in  1  one-cycle pulse from decoder: undefined instruction.
- `swi_req`  in  1  one-cycle pulse from decoder: SWI executed.
- `instr_done`  in  1  current instruction retired; exceptions taken only here.
- `cpsr`  in  32  current CPSR.
- `pc_cur`  in  32  address of the next sequential instruction.
- `busy`  out  1  entry sequence in progress; control unit must stall.
- `change_m`  out  3  register-bank override: 0 none, 1 fiq, 2 irq, 3 svc, 4 und.
- `write_reg`  out  1  register-file write strobe.
- `w_addr`  out  4  register-file write address.
- `w_data`  out  32  register-file write data.
- `write_pc`  out  1  PC load strobe.
- `pc_new`  out  32  new PC value.
- `cpsr_we`  out  1  CPSR write strobe.
- `cpsr_new`  out  32  new CPSR value.
- `spsr_we`  out  1  SPSR write strobe.
- `spsr_mode`  out  5  mode whose SPSR is written.
- `spsr_data`  out  32  value written to the SPSR.
- `exc_taken`  out  3  one-cycle pulse code of the taken exception (0 none, 1 fiq, 2 irq, 3 swi, 4 und).

## Operation
- **Pending latches:** `und_req` and `swi_req` pulses set `und_pend` / `swi_pend`, which stay set until serviced. A pulse arriving while `busy` is still latched.
- **Selection:** in IDLE with `instr_done`=1, the candidates are:
  - FIQ: `fiq` && !`cpsr[6]`.
  - IRQ: `irq` && !`cpsr[7]`.
  - UND: `und_pend`.
  - SWI: `swi_pend`.
  - Priority: FIQ > IRQ > UND > SWI. If no candidate, stay IDLE.
- **Capture on selection:** `cpsr` → `saved_psr`; the LR value; target mode (fiq 10001, irq 10010, und 11011, swi→svc 10011); the `change_m` code; the vector offset (und 0x04, swi 0x08, irq 0x18, fiq 0x1C). Clear the selected pending latch. Pulse `exc_taken`.
- **LR value:**
  - FIQ/IRQ: `pc_cur`+4.
  - UND/SWI: `pc_cur`.
  - 32-bit wrap-around, no carry out.
- **FSM:** IDLE → SAVE_LR → SAVE_PSR → LOAD_PC → IDLE.
  - SAVE_LR: `write_reg`=1, `w_addr`=14, `w_data`=LR, `change_m`=code.
  - SAVE_PSR:
    - `spsr_we`=1, `spsr_mode`=target, `spsr_data`=`saved_psr`.
    - `cpsr_we`=1, `cpsr_new`=`saved_psr` with [4:0]=target, [7]=1, [5]=0, [6]=1 only for FIQ (else unchanged).
    - `change_m`=code.
  - LOAD_PC: `write_pc`=1, `pc_new`=`VECTOR_BASE`+offset, `change_m`=0 (CPSR now selects the bank).
- **Strobes:** all strobes are 0 outside their state; `w_addr`/`w_data`/`pc_new` are 0 when their strobe is 0.
- **Ignored during `busy`:** `instr_done`, and changes on `fiq`/`irq`. A level request dropped before selection is never taken.

## Timing
- All outputs are registered; each strobe is asserted for exactly one cycle.
- Selection edge E: `busy`=1 and `exc_taken` pulse from E+1. SAVE_LR is visible during E+1, SAVE_PSR during E+2, LOAD_PC during E+3. `busy`=0 from E+4.
- Earliest next selection: an `instr_done` sampled at E+4.
- Back-to-back: an IRQ still pending after FIQ entry is masked by the new CPSR (I=1, supplied by the core) and not taken.
- Simultaneous `und_req` pulse and selection edge: the latch is set; it is taken at a later boundary.
- Reset: any cycle with `rst`=1 forces IDLE, clears both pending latches and drives every output to 0 on the next edge.
  - Reset mid-sequence aborts it; no further strobes are issued.

## Structure
- Package `exc_pkg` holds:
  - mode constants (USR, FIQ, IRQ, SVC, UND, SYS);
  - `change_m` codes and `exc_taken` codes;
  - vector offsets;
  - the FSM state enum;
  - CPSR bit indices (`I_BIT`=7, `F_BIT`=6, `T_BIT`=5).
- One combinational sub-module, `exc_priority_enc`: masks and pending inputs in, selected code plus valid out.

## Test plan
- `cpsr`=0x10, `irq`=1, `instr_done`, `pc_cur`=0x100 → LR write r14=0x104 with `change_m`=2; SPSR(10010)=0x10; CPSR=0x92; PC=0x18; `busy` for 3 cycles.
- `fiq`=`irq`=1, `cpsr`=0x10 → FIQ taken, `cpsr_new`=0xD1, PC=0x1C; IRQ not taken afterwards while the core reports `cpsr`=0xD1.
- `cpsr`=0x90 (I set), `irq`=1, `swi_req` pulse, `pc_cur`=0x200 → SWI taken, r14=0x200 with `change_m`=3, CPSR=0x93, PC=0x08.
- `und_req` pulse while `busy` → UND taken at the first `instr_done` after `busy` falls; PC=0x04, `spsr_mode`=11011.
- `rst` asserted during SAVE_PSR → no `write_pc`, all outputs 0 next cycle, pending latches cleared.
- `VECTOR_BASE`=0xFFFF0000, IRQ → `pc_new`=0xFFFF0018.
